// File: rtl/bram_packer_if.sv
// Pipe-in and BRAM-write signal bundle for bram_packer; channel c owns slice c of every vector.
// The master drives the pipe side, the slave (packer) drives the BRAM side.
interface bram_packer_if #(
  parameter int NCH       = 3,
  parameter int IN_W      = 32,
  parameter int ELEM_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 13
);
  localparam int FW = $clog2(BURST_LEN + 1);

  logic [NCH-1:0]                  pass_mode;
  logic [NCH-1:0]                  in_valid;
  logic [NCH*IN_W-1:0]             in_data;
  logic [NCH-1:0]                  flush;
  logic [NCH-1:0]                  clear;
  logic [NCH-1:0]                  ram_wr_en;
  logic [NCH*ADDR_W-1:0]           ram_addr;
  logic [NCH*BURST_LEN*ELEM_W-1:0] ram_data;
  logic [NCH*FW-1:0]               fill_count;
  logic [NCH-1:0]                  overflow;

  modport master (
    output pass_mode, in_valid, in_data, flush, clear,
    input  ram_wr_en, ram_addr, ram_data, fill_count, overflow
  );

  modport slave (
    input  pass_mode, in_valid, in_data, flush, clear,
    output ram_wr_en, ram_addr, ram_data, fill_count, overflow
  );
endinterface

// File: rtl/bram_packer.sv
// Multi-channel pipe-to-BRAM packer: each channel packs BURST_LEN elements into one wide word
// (or passes words straight through) and writes it with a self-incrementing address.
module bram_packer #(
  parameter int NCH       = 3,
  parameter int IN_W      = 32,
  parameter int ELEM_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 13
) (
  input logic         clk,
  input logic         rst,
  bram_packer_if.slave bus
);
  localparam int BW = BURST_LEN * ELEM_W;
  localparam int FW = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [NCH-1:0]        wr_en_all;
  logic [NCH-1:0]        ovf_all;
  logic [NCH*ADDR_W-1:0] addr_all;
  logic [NCH*BW-1:0]     data_all;
  logic [NCH*FW-1:0]     fill_all;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [BW-1:0]     lanes_q, lanes_d;
      logic [BW-1:0]     data_q, data_d;
      logic [FW-1:0]     fill_q, fill_d;
      logic [ADDR_W-1:0] addr_q, addr_d;
      logic              wr_en_q, wr_en_d;
      logic              ovf_q, ovf_d;
      logic [ELEM_W-1:0] elem;
      logic [BW-1:0]     elem_top;
      logic [BW-1:0]     lanes_eff;
      int                k;
      int                shamt;

      assign elem     = bus.in_data[gi*IN_W +: ELEM_W];
      assign elem_top = BW'(elem) << (BW - ELEM_W);

      always_comb begin
        lanes_d   = lanes_q;
        data_d    = data_q;
        fill_d    = fill_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        ovf_d     = ovf_q;
        lanes_eff = lanes_q;
        k         = 0;
        shamt     = 0;

        // The write currently on the output retires its address at this edge.
        if (wr_en_q) begin
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == ADDR_MAX) begin
            ovf_d = 1'b1;
          end
        end

        if (bus.clear[gi]) begin
          lanes_d = '0;
          fill_d  = '0;
          addr_d  = '0;
          ovf_d   = 1'b0;
        end else if (bus.pass_mode[gi]) begin
          if (bus.in_valid[gi]) begin
            data_d  = BW'(bus.in_data[gi*IN_W +: IN_W]);
            wr_en_d = 1'b1;
          end
        end else begin
          // Element is accepted before any flush so a same-cycle flush covers it.
          k = int'(fill_q) + int'(bus.in_valid[gi]);
          if (bus.in_valid[gi]) begin
            lanes_eff = (lanes_q >> ELEM_W) | elem_top;
          end
          lanes_d = lanes_eff;
          if (k == BURST_LEN) begin
            data_d  = lanes_eff;
            wr_en_d = 1'b1;
            fill_d  = '0;
          end else if (bus.flush[gi] && k > 0) begin
            // Buffered elements sit in the top k lanes; drop them to lanes 0..k-1.
            shamt   = (BURST_LEN - k) * ELEM_W;
            data_d  = lanes_eff >> shamt;
            wr_en_d = 1'b1;
            fill_d  = '0;
          end else begin
            fill_d = FW'(k);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          lanes_q <= '0;
          data_q  <= '0;
          fill_q  <= '0;
          addr_q  <= '0;
          wr_en_q <= 1'b0;
          ovf_q   <= 1'b0;
        end else begin
          lanes_q <= lanes_d;
          data_q  <= data_d;
          fill_q  <= fill_d;
          addr_q  <= addr_d;
          wr_en_q <= wr_en_d;
          ovf_q   <= ovf_d;
        end
      end

      assign wr_en_all[gi]              = wr_en_q;
      assign ovf_all[gi]                = ovf_q;
      assign addr_all[gi*ADDR_W +: ADDR_W] = addr_q;
      assign data_all[gi*BW +: BW]      = data_q;
      assign fill_all[gi*FW +: FW]      = fill_q;
    end
  endgenerate

  assign bus.ram_wr_en  = wr_en_all;
  assign bus.overflow   = ovf_all;
  assign bus.ram_addr   = addr_all;
  assign bus.ram_data   = data_all;
  assign bus.fill_count = fill_all;
endmodule

// File: tb/tb_bram_packer.sv
// Bench for bram_packer: a default 3-channel instance plus a 1-lane, 4-bit-address instance
// for wrap behaviour, checked every cycle against an element-queue reference model.
module tb_bram_packer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_packer_if #(.NCH(3)) bus_a ();
  bram_packer_if #(.NCH(1), .BURST_LEN(1), .ADDR_W(4)) bus_w ();

  bram_packer #(.NCH(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  bram_packer #(.NCH(1), .BURST_LEN(1), .ADDR_W(4)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: per channel a list of buffered elements and the expected output registers.
  // Channels 0..2 model dut_a, channel 3 models dut_w.
  logic [15:0]  m_buf  [4][8];
  int           m_cnt  [4] = '{0, 0, 0, 0};
  bit           m_wr   [4] = '{0, 0, 0, 0};
  int           m_addr [4] = '{0, 0, 0, 0};
  bit           m_ovf  [4] = '{0, 0, 0, 0};
  logic [127:0] m_data [4];

  typedef struct {
    bit           v;
    logic [31:0]  d;
    bit           fl;
    bit           clr;
    bit           pas;
    bit           e_wr;
    int           e_addr;
    logic [127:0] e_data;
    int           e_fill;
  } vec_t;
  vec_t tbl [22];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_chan(input int c, input int bl, input int aw, input bit r, input bit clr,
                            input bit pas, input bit v, input bit fl, input logic [31:0] d);
    int na;
    bit no;
    logic [127:0] mask;
    if (r) begin
      m_cnt[c] = 0; m_wr[c] = 0; m_addr[c] = 0; m_ovf[c] = 0; m_data[c] = '0;
    end else begin
      na = m_addr[c];
      no = m_ovf[c];
      if (m_wr[c]) begin
        na = m_addr[c] + 1;
        if (na == (1 << aw)) begin
          na = 0;
          no = 1;
        end
      end
      m_wr[c] = 0;
      if (clr) begin
        m_cnt[c] = 0; m_addr[c] = 0; m_ovf[c] = 0;
      end else begin
        m_addr[c] = na;
        m_ovf[c]  = no;
        if (pas) begin
          if (v) begin
            mask      = (128'd1 << (bl * 16)) - 128'd1;
            m_data[c] = 128'(d) & mask;
            m_wr[c]   = 1;
          end
        end else begin
          if (v) begin
            m_buf[c][m_cnt[c]] = d[15:0];
            m_cnt[c]++;
          end
          if (m_cnt[c] == bl || (fl && m_cnt[c] > 0)) begin
            m_data[c] = '0;
            for (int i = 0; i < m_cnt[c]; i++) m_data[c][i*16 +: 16] = m_buf[c][i];
            m_wr[c]  = 1;
            m_cnt[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 3; c++)
      model_chan(c, 8, 13, rst, bus_a.clear[c], bus_a.pass_mode[c], bus_a.in_valid[c],
                 bus_a.flush[c], bus_a.in_data[c*32 +: 32]);
    model_chan(3, 1, 4, rst, bus_w.clear[0], bus_w.pass_mode[0], bus_w.in_valid[0],
               bus_w.flush[0], bus_w.in_data);
  endtask

  task automatic model_check();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("m ch%0d wr_en", c), 128'(bus_a.ram_wr_en[c]), 128'(m_wr[c]));
      chk($sformatf("m ch%0d addr", c), 128'(bus_a.ram_addr[c*13 +: 13]), 128'(m_addr[c]));
      chk($sformatf("m ch%0d fill", c), 128'(bus_a.fill_count[c*4 +: 4]), 128'(m_cnt[c]));
      chk($sformatf("m ch%0d ovf", c), 128'(bus_a.overflow[c]), 128'(m_ovf[c]));
      if (m_wr[c]) chk($sformatf("m ch%0d data", c), bus_a.ram_data[c*128 +: 128], m_data[c]);
    end
    chk("m w wr_en", 128'(bus_w.ram_wr_en), 128'(m_wr[3]));
    chk("m w addr", 128'(bus_w.ram_addr), 128'(m_addr[3]));
    chk("m w fill", 128'(bus_w.fill_count), 128'(m_cnt[3]));
    chk("m w ovf", 128'(bus_w.overflow), 128'(m_ovf[3]));
    if (m_wr[3]) chk("m w data", 128'(bus_w.ram_data), m_data[3]);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle();
    bus_a.in_valid = '0; bus_a.in_data = '0; bus_a.flush = '0; bus_a.clear = '0;
    bus_w.in_valid = '0; bus_w.in_data = '0; bus_w.flush = '0; bus_w.clear = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " wr_en"}, 128'(bus_a.ram_wr_en), 128'd0);
    chk({tag, " addr"}, 128'(bus_a.ram_addr), 128'd0);
    chk({tag, " data"}, 128'(|bus_a.ram_data), 128'd0);
    chk({tag, " fill"}, 128'(bus_a.fill_count), 128'd0);
    chk({tag, " ovf"}, 128'(bus_a.overflow), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Partial flush, flush at zero fill, flush with 8th element, and pass mode on channel 2.
    tbl[0]  = '{0, 32'h0, 0, 1, 0, 0, 0, '0, 0};
    for (int j = 0; j < 4; j++)
      tbl[1+j] = '{1, 32'hDEADBEEF, 0, 0, 1, 1, j, 128'hDEADBEEF, 0};
    tbl[5]  = '{0, 32'h0, 0, 0, 0, 0, 4, '0, 0};
    tbl[6]  = '{1, 32'hA, 0, 0, 0, 0, 4, '0, 1};
    tbl[7]  = '{1, 32'hB, 0, 0, 0, 0, 4, '0, 2};
    tbl[8]  = '{1, 32'hC, 0, 0, 0, 0, 4, '0, 3};
    tbl[9]  = '{0, 32'h0, 1, 0, 0, 1, 4, 128'h000C_000B_000A, 0};
    tbl[10] = '{0, 32'h0, 1, 0, 0, 0, 5, '0, 0};
    for (int j = 0; j < 7; j++)
      tbl[11+j] = '{1, 32'h11 + 32'(j), 0, 0, 0, 0, 5, '0, j + 1};
    tbl[18] = '{1, 32'h18, 1, 0, 0, 1, 5, 128'h0018_0017_0016_0015_0014_0013_0012_0011, 0};
    tbl[19] = '{0, 32'h0, 0, 0, 0, 0, 6, '0, 0};
    tbl[20] = '{1, 32'h1234_0021, 0, 0, 0, 0, 6, '0, 1};
    tbl[21] = '{1, 32'h22, 1, 0, 0, 1, 6, 128'h0022_0021, 0};

    rst = 1'b1;
    bus_a.pass_mode = '0;
    bus_w.pass_mode = '0;
    idle();
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Reset held for 3 cycles in the middle of a burst.
    for (int i = 0; i < 3; i++) begin
      bus_a.in_valid[0] = 1'b1;
      bus_a.in_data[31:0] = 32'h100 + 32'(i);
      cycle();
    end
    rst = 1'b1;
    bus_a.in_valid = '1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_all_zero("rst held");
    end
    rst = 1'b0;
    idle();
    cycle();
    chk_all_zero("rst released");
    for (int i = 1; i <= 8; i++) begin
      bus_a.in_valid[0] = 1'b1;
      bus_a.in_data[31:0] = 32'(i);
      cycle();
    end
    chk("t1 wr_en", 128'(bus_a.ram_wr_en[0]), 128'd1);
    chk("t1 addr", 128'(bus_a.ram_addr[12:0]), 128'd0);
    chk("t1 lane0", 128'(bus_a.ram_data[15:0]), 128'h0001);
    chk("t1 lane7", 128'(bus_a.ram_data[127:112]), 128'h0008);
    $display("txn t1: ch0 write addr=%0d data=0x%0h", bus_a.ram_addr[12:0], bus_a.ram_data[127:0]);
    idle();
    cycle();
    chk("t1 single pulse", 128'(bus_a.ram_wr_en[0]), 128'd0);

    // Streaming 24 elements on channel 1.
    for (int i = 1; i <= 24; i++) begin
      bus_a.in_valid[1] = 1'b1;
      bus_a.in_data[63:32] = $urandom;
      cycle();
      chk("t2 fill", 128'(bus_a.fill_count[7:4]), 128'(i % 8));
      chk("t2 wr_en", 128'(bus_a.ram_wr_en[1]), 128'(i % 8 == 0));
      if (i % 8 == 0) begin
        chk("t2 addr", 128'(bus_a.ram_addr[25:13]), 128'(i / 8 - 1));
        $display("txn t2: ch1 write addr=%0d data=0x%0h", bus_a.ram_addr[25:13], bus_a.ram_data[255:128]);
      end
    end
    idle();
    cycle();

    // Table-driven rows on channel 2.
    for (int i = 0; i < 22; i++) begin
      bus_a.in_valid[2]    = tbl[i].v;
      bus_a.in_data[95:64] = tbl[i].d;
      bus_a.flush[2]       = tbl[i].fl;
      bus_a.clear[2]       = tbl[i].clr;
      bus_a.pass_mode[2]   = tbl[i].pas;
      cycle();
      chk($sformatf("tbl[%0d] wr_en", i), 128'(bus_a.ram_wr_en[2]), 128'(tbl[i].e_wr));
      chk($sformatf("tbl[%0d] addr", i), 128'(bus_a.ram_addr[38:26]), 128'(tbl[i].e_addr));
      chk($sformatf("tbl[%0d] fill", i), 128'(bus_a.fill_count[11:8]), 128'(tbl[i].e_fill));
      if (tbl[i].e_wr) chk($sformatf("tbl[%0d] data", i), bus_a.ram_data[383:256], tbl[i].e_data);
      $display("txn tbl[%0d]: wr=%0d addr=%0d fill=%0d data=0x%0h", i, bus_a.ram_wr_en[2],
               bus_a.ram_addr[38:26], bus_a.fill_count[11:8], bus_a.ram_data[383:256]);
    end
    idle();
    bus_a.pass_mode = '0;
    cycle();

    // Address wrap on the 1-lane, 4-bit-address instance.
    for (int i = 1; i <= 17; i++) begin
      bus_w.in_valid = 1'b1;
      bus_w.in_data  = 32'(i);
      cycle();
      chk("t5 wr_en", 128'(bus_w.ram_wr_en), 128'd1);
      chk("t5 addr", 128'(bus_w.ram_addr), 128'((i - 1) % 16));
      chk("t5 ovf", 128'(bus_w.overflow), 128'(i >= 17));
      $display("txn t5: write %0d addr=%0d ovf=%0d", i, bus_w.ram_addr, bus_w.overflow);
    end
    idle();
    cycle();
    chk("t5 ovf sticky", 128'(bus_w.overflow), 128'd1);
    bus_w.clear = 1'b1;
    cycle();
    bus_w.clear = 1'b0;
    chk("t5 clr ovf", 128'(bus_w.overflow), 128'd0);
    chk("t5 clr addr", 128'(bus_w.ram_addr), 128'd0);
    bus_w.in_valid = 1'b1;
    bus_w.in_data  = 32'h55;
    cycle();
    chk("t5 post clr addr", 128'(bus_w.ram_addr), 128'd0);
    chk("t5 post clr data", 128'(bus_w.ram_data), 128'h55);
    idle();
    cycle();

    // All channels together, then clear channel 0 mid-burst.
    bus_a.clear = '1;
    cycle();
    bus_a.clear = '0;
    for (int i = 0; i < 5; i++) begin
      bus_a.in_valid = '1;
      bus_a.in_data  = {$urandom, $urandom, $urandom};
      cycle();
    end
    bus_a.clear[0] = 1'b1;
    bus_a.in_data  = {$urandom, $urandom, $urandom};
    cycle();
    bus_a.clear[0] = 1'b0;
    chk("t6 ch0 fill", 128'(bus_a.fill_count[3:0]), 128'd0);
    chk("t6 ch1 fill", 128'(bus_a.fill_count[7:4]), 128'd6);
    chk("t6 ch2 fill", 128'(bus_a.fill_count[11:8]), 128'd6);
    cycle();
    chk("t6 ch0 restart", 128'(bus_a.fill_count[3:0]), 128'd1);
    cycle();
    chk("t6 ch1 wr", 128'(bus_a.ram_wr_en[1]), 128'd1);
    chk("t6 ch2 wr", 128'(bus_a.ram_wr_en[2]), 128'd1);
    chk("t6 ch0 no wr", 128'(bus_a.ram_wr_en[0]), 128'd0);
    repeat (6) cycle();
    chk("t6 ch0 wr", 128'(bus_a.ram_wr_en[0]), 128'd1);
    chk("t6 ch0 addr", 128'(bus_a.ram_addr[12:0]), 128'd0);
    $display("txn t6: ch0 write addr=%0d data=0x%0h", bus_a.ram_addr[12:0], bus_a.ram_data[127:0]);
    idle();
    cycle();

    // Randomized traffic checked by the model on every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < 3; c++) begin
        bus_a.in_valid[c]       = ($urandom_range(0, 99) < 60);
        bus_a.in_data[c*32 +: 32] = $urandom;
        bus_a.flush[c]          = ($urandom_range(0, 99) < 8);
        bus_a.clear[c]          = ($urandom_range(0, 199) == 0);
        if (m_cnt[c] == 0 && $urandom_range(0, 39) == 0) begin
          bus_a.pass_mode[c] = ~bus_a.pass_mode[c];
          bus_a.in_valid[c]  = 1'b0;
        end
      end
      bus_w.in_valid = ($urandom_range(0, 99) < 70);
      bus_w.in_data  = $urandom;
      bus_w.flush    = ($urandom_range(0, 99) < 5);
      bus_w.clear    = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) begin
        bus_w.pass_mode = ~bus_w.pass_mode;
        bus_w.in_valid  = 1'b0;
      end
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/bram_packer.md
# bram_packer

Parametrised multi-channel packer between the host block-throttled pipe-in endpoints and the on-chip data, weight and bias BRAMs, all in the host (okClk) domain. Each channel takes 32-bit pipe words, keeps the low ELEM_W bits, packs BURST_LEN elements into one wide BRAM word and issues a single-cycle write with a self-incrementing address. It generalises the fixed d/w/b write logic with:

- a parametrised channel count and burst geometry;
- a per-channel pass-through mode for bias;
- explicit flush of partial bursts;
- a per-channel clear;
- sticky address-wrap detection.

## Interface

Parameters:

- NCH, 3: number of independent channels (0 = data, 1 = weight, 2 = bias by convention).
- IN_W, 32: pipe word width.
- ELEM_W, 16: element width taken from in_data[ELEM_W-1:0] in pack mode.
- BURST_LEN, 8: elements per BRAM word; ≥1.
- ADDR_W, 13: address width per channel; all channels share the same width.

Ports:

- clk  in  1  host clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- pass_mode  in  NCH  per channel: 0 = pack, 1 = pass-through. Sampled every cycle; change only while the channel is idle.
- in_valid  in  NCH  per-channel pipe write strobe.
- in_data  in  NCH*IN_W  channel c occupies [c*IN_W +: IN_W].
- flush  in  NCH  per-channel pulse that writes out a partial burst.
- clear  in  NCH  per-channel pulse that resets the channel's address, fill count, lanes and overflow.
- ram_wr_en  out  NCH  single-cycle write strobe per channel.
- ram_addr  out  NCH*ADDR_W  BRAM address per channel. Valid whenever ram_wr_en is high.
- ram_data  out  NCH*BURST_LEN*ELEM_W  packed word per channel. Lane 0 (LSBs) holds the oldest element.
- fill_count  out  NCH*$clog2(BURST_LEN+1)  elements currently buffered per channel.
- overflow  out  NCH  sticky flag; set when the channel's address wraps.

## Operation

All channels are identical and fully independent; there is no arbitration.

Pack mode (per channel):

- Each in_valid shifts in_data[ELEM_W-1:0] into the top lane and shifts the existing lanes down one lane.
- fill_count increments by 1 per accepted element.
- When an accepted element makes fill_count reach BURST_LEN:
  - the packed word is registered on ram_data;
  - ram_wr_en pulses for one cycle;
  - fill_count returns to 0.

Pass-through mode:

- Each in_valid produces a write immediately.
- The write data is in_data zero-extended, or truncated to BURST_LEN*ELEM_W bits.
- fill_count stays 0.

Flush:

- With fill_count = k > 0, flush writes the k buffered elements into lanes 0..k-1 and zeros into the upper lanes. This is done by right-shifting the lane register by (BURST_LEN-k)*ELEM_W.
- fill_count returns to 0.
- With k = 0, flush has no effect.
- If flush and in_valid arrive in the same cycle, the element is accepted first and the flush then covers it. Exactly one write results, including when that element completes a full burst.

Addressing:

- ram_addr holds the address of the current or next write.
- ram_addr increments on every clock edge at which ram_wr_en is high.
- Back-to-back writes therefore land on consecutive addresses.
- Incrementing from 2^ADDR_W-1 wraps the address to 0 and sets overflow.

Priority within a channel, per cycle: rst > clear > (in_valid, then flush).

- clear zeroes the address, fill_count, lanes and overflow.
- Any element or flush presented in the same cycle as clear is dropped.
- A ram_wr_en pulse already on the output when clear arrives completes normally. The address then restarts at 0, not at the incremented value.

Reset:

- All outputs are 0 while rst is high, and on the first cycle after rst is released.
- The lanes are also zeroed.
- The result of an in-flight burst is discarded.

## Timing

- Latency: the accepting or flushing cycle is t; ram_wr_en is high in cycle t+1 with ram_data and ram_addr stable.
- Throughput is one element per cycle per channel, with no backpressure. Pass mode can sustain one write per cycle.
- ram_wr_en is never high for more than one cycle per burst. It is high for consecutive cycles only when consecutive bursts complete (pass mode, or BURST_LEN = 1).
- overflow is set on the edge where the address wraps and remains set until rst or clear.
- fill_count updates on the same edge as the accepted element.

## Test plan

1. **Reset:** hold rst for 3 cycles mid-burst.
   - Required: every output is 0.
   - Then send 8 elements 0x0001..0x0008 on channel 0 (defaults). Required: one ram_wr_en at addr 0, with ram_data lane0 = 0x0001 and lane7 = 0x0008.
2. **Streaming:** send 24 consecutive elements on channel 1.
   - Required: writes at addr 0, 1, 2 in cycles t+1 after the 8th, 16th and 24th elements.
   - Required: fill_count cycles 0..7.
3. **Partial flush:** send 3 elements 0xA, 0xB, 0xC, then flush.
   - Required: a single write with lane0 = 0xA, lane1 = 0xB, lane2 = 0xC, lanes 3..7 = 0.
   - Also: flush at fill_count 0 produces no write. Flush together with the 8th element produces exactly one write.
4. **Pass mode:** set pass_mode[2] and send 0xDEADBEEF on 4 consecutive cycles.
   - Required: 4 back-to-back ram_wr_en pulses at addr 0..3.
   - Required: ram_data[31:0] = 0xDEADBEEF with upper bits 0.
5. **Wrap:** with ADDR_W = 4 and BURST_LEN = 1, send 17 elements.
   - Required: the 17th write lands at addr 0 and overflow goes high on the 16th increment.
   - Then clear. Required: overflow = 0 and the next write lands at addr 0.
6. **Independence/clear:** drive all 3 channels simultaneously, then clear channel 0 mid-burst.
   - Required: channels 1 and 2 are unaffected.
   - Required: channel 0 restarts at fill_count 0, and the element presented with clear is dropped.
